// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a WS2812 single-wire pixel stream into GRB bytes with frame bookkeeping.
// Define WS2812_RX_PASSTHRU_EN to add do_o, which forwards pixels beyond NUM_LEDS downstream.
module ws2812_rx #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        di_i,
  output logic                        pix_valid_o,
  output logic [$clog2(NUM_LEDS)-1:0] address_o,
  output logic [7:0]                  green_o,
  output logic [7:0]                  red_o,
  output logic [7:0]                  blue_o,
  output logic                        frame_done_o,
  output logic [$clog2(NUM_LEDS):0]   led_count_o,
  output logic                        busy_o,
  output logic                        err_o
`ifdef WS2812_RX_PASSTHRU_EN
  ,
  output logic                        do_o
`endif
);

  localparam int AW      = $clog2(NUM_LEDS);
  localparam int IW      = AW + 1;
  localparam int U       = SYSTEM_CLOCK / 1000000;
  localparam int T_MIN   = U * 15 / 100;
  localparam int T_SPLIT = U * 6 / 10;
  localparam int T_MAX   = U * 15 / 10;
  localparam int T_RESET = U * 50;
  localparam int CW      = $clog2(T_RESET + 1);

  localparam logic [CW-1:0] T_MIN_C     = CW'(T_MIN);
  localparam logic [CW-1:0] T_SPLIT_C   = CW'(T_SPLIT);
  localparam logic [CW-1:0] T_MAX_C     = CW'(T_MAX);
  localparam logic [CW-1:0] T_RESET_C   = CW'(T_RESET);
  localparam logic [CW-1:0] T_RESET_M1  = CW'(T_RESET - 1);
  localparam logic [IW-1:0] NUM_LEDS_C  = IW'(NUM_LEDS);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  logic          sync1_q, sync2_q, sync3_q;
  logic          rise, fall;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    bitcnt_q, bitcnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          frame_done_q, frame_done_d;
  logic [IW-1:0] led_count_q, led_count_d;

  logic          pix_valid_q;
  logic [AW-1:0] address_q;
  logic [7:0]    green_q, red_q, blue_q;

`ifdef WS2812_RX_PASSTHRU_EN
  logic          fwd_q, fwd_d;
`endif

  // di_i is asynchronous: only sync2_q/sync3_q may feed decode logic.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= di_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise = sync2_q & ~sync3_q;
  assign fall = ~sync2_q & sync3_q;

  // The width counter restarts at one on an edge so that it equals the level's width in cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    pend_d       = 1'b0;
    pend_addr_d  = pend_addr_q;
    busy_d       = busy_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    led_count_d  = led_count_q;
`ifdef WS2812_RX_PASSTHRU_EN
    fwd_d        = fwd_q;
    if (busy_q && (idx_q == NUM_LEDS_C) && !sync2_q) begin
      fwd_d = 1'b1;
    end
`endif

    case (state_q)
      ST_SYNC: begin
        if (sync2_q) begin
          cnt_d = '0;
        end else if (cnt_q >= T_RESET_M1) begin
          cnt_d   = T_RESET_C;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          state_d  = ST_HIGH;
          cnt_d    = CW'(1);
          bitcnt_d = '0;
          idx_d    = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
`ifdef WS2812_RX_PASSTHRU_EN
          fwd_d    = 1'b0;
`endif
        end
      end

      ST_HIGH: begin
        if (fall) begin
          if (cnt_q < T_MIN_C) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            state_d = ST_SYNC;
`ifdef WS2812_RX_PASSTHRU_EN
            fwd_d   = 1'b0;
`endif
          end else begin
            shift_d = {shift_q[22:0], (cnt_q >= T_SPLIT_C)};
            cnt_d   = CW'(1);
            state_d = ST_LOW;
            if (bitcnt_q == 5'd23) begin
              bitcnt_d = '0;
              if (idx_q < NUM_LEDS_C) begin
                pend_d      = 1'b1;
                pend_addr_d = idx_q[AW-1:0];
                idx_d       = idx_q + 1'b1;
              end
            end else begin
              bitcnt_d = bitcnt_q + 1'b1;
            end
          end
        end else if (cnt_q >= T_MAX_C) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = ST_SYNC;
`ifdef WS2812_RX_PASSTHRU_EN
          fwd_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = CW'(1);
        end else if (cnt_q >= T_RESET_M1) begin
          // A partial trailing pixel is dropped but flagged.
          cnt_d        = T_RESET_C;
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          led_count_d  = idx_q;
          busy_d       = 1'b0;
          if (bitcnt_q != 5'd0) begin
            err_d = 1'b1;
          end
`ifdef WS2812_RX_PASSTHRU_EN
          fwd_d        = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
      led_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
      led_count_q  <= led_count_d;
    end
  end

  // Pixel publish stage; shift_q is stable here because a new bit needs a full low phase.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      pix_valid_q <= 1'b0;
      address_q   <= '0;
      green_q     <= '0;
      red_q       <= '0;
      blue_q      <= '0;
    end else begin
      pix_valid_q <= pend_q;
      if (pend_q) begin
        address_q <= pend_addr_q;
        green_q   <= shift_q[23:16];
        red_q     <= shift_q[15:8];
        blue_q    <= shift_q[7:0];
      end
    end
  end

`ifdef WS2812_RX_PASSTHRU_EN
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      fwd_q <= 1'b0;
    end else begin
      fwd_q <= fwd_d;
    end
  end

  assign do_o = fwd_q & sync2_q;
`endif

  assign pix_valid_o  = pix_valid_q;
  assign address_o    = address_q;
  assign green_o      = green_q;
  assign red_o        = red_q;
  assign blue_o       = blue_q;
  assign frame_done_o = frame_done_q;
  assign led_count_o  = led_count_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: drives WS2812 frames (fixed and random colours) and checks reports against a frame-level model.
module tb_ws2812_rx;
  localparam int NUM_LEDS = 8;
  localparam int T0H = 20, T0L = 42, T1H = 40, T1L = 22;
  localparam int TAIL = 2600;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic di = 1'b0;
  logic pix_valid, frame_done, busy, err;
  logic [2:0] address;
  logic [7:0] green, red, blue;
  logic [3:0] led_count;
`ifdef WS2812_RX_PASSTHRU_EN
  logic do_line;
  logic do_prev = 1'b0;
`endif

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .SYSTEM_CLOCK(50000000)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .di_i(di),
    .pix_valid_o(pix_valid), .address_o(address),
    .green_o(green), .red_o(red), .blue_o(blue),
    .frame_done_o(frame_done), .led_count_o(led_count),
    .busy_o(busy), .err_o(err)
`ifdef WS2812_RX_PASSTHRU_EN
    , .do_o(do_line)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int addr; logic [23:0] grb; int due; } exp_pix_t;
  typedef struct { int npix; int extra_bits; int exp_count; logic exp_err; } vec_t;

  exp_pix_t exp_q[$];
  exp_pix_t mon_e;
  vec_t vecs[4];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int do_bad = 0;
  int do_rises = 0;
  logic [23:0] last_grb = '0;
  int last_addr = 0;
  logic fwd_win = 1'b0;
  logic di_p1 = 1'b0, di_p2 = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    di_p1 <= di;
    di_p2 <= di_p1;
  end

  // Monitor: every pix_valid pulse must match the oldest expected pixel, on its due cycle.
  always @(negedge clk) begin
    if (pix_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pix_valid: unexpected pulse cycle=%0d addr=%0d grb=%06h, required no pulse",
                 cyc, address, {green, red, blue});
      end else begin
        mon_e = exp_q.pop_front();
        if (address !== mon_e.addr[2:0] || {green, red, blue} !== mon_e.grb || cyc != mon_e.due) begin
          errors++;
          $display("FAIL pixel: got addr=%0d grb=%06h cycle=%0d, required addr=%0d grb=%06h cycle=%0d",
                   address, {green, red, blue}, cyc, mon_e.addr, mon_e.grb, mon_e.due);
        end else begin
          $display("pixel addr=%0d grb=%06h cycle=%0d ok", address, {green, red, blue}, cyc);
        end
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].due) begin
      checks++;
      errors++;
      $display("FAIL pix_missing: got no pulse by cycle %0d, required addr=%0d grb=%06h",
               cyc, exp_q[0].addr, exp_q[0].grb);
      mon_e = exp_q.pop_front();
    end
    if (frame_done === 1'b1) fd_count++;
`ifdef WS2812_RX_PASSTHRU_EN
    if (do_line !== (fwd_win ? di_p2 : 1'b0)) do_bad++;
    if (do_line === 1'b1 && do_prev !== 1'b1) do_rises++;
    do_prev = do_line;
`endif
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_low(input int n);
    di = 1'b0;
    repeat (n) tick();
  endtask

  // Sends the top nbits of grb MSB first; a complete reported pixel is queued as expected output.
  task automatic send_bits(input logic [23:0] grb, input int nbits, input logic report, input int addr);
    exp_pix_t e;
    for (int i = 23; i > 23 - nbits; i--) begin
      di = 1'b1;
      repeat (grb[i] ? T1H : T0H) tick();
      di = 1'b0;
      if (i == 0 && report) begin
        e.addr = addr;
        e.grb  = grb;
        e.due  = cyc + 4;
        exp_q.push_back(e);
        last_grb  = grb;
        last_addr = addr;
      end
      repeat (grb[i] ? T1L : T0L) tick();
    end
  endtask

  task automatic run_frame(input int npix, input int extra);
    logic [23:0] px;
    fd_count = 0;
    for (int p = 0; p < npix; p++) begin
      px = 24'($urandom);
      if (p == NUM_LEDS) fwd_win = 1'b1;
      send_bits(px, 24, (p < NUM_LEDS), p);
    end
    if (extra > 0) begin
      px = 24'($urandom);
      send_bits(px, extra, 1'b0, 0);
    end
    hold_low(TAIL);
    fwd_win = 1'b0;
  endtask

  task automatic check_frame(input int exp_fd, input int exp_count, input logic exp_err, input int fwd_bits);
    chk("frame_done_pulses", fd_count, exp_fd);
    chk("led_count", led_count, exp_count);
    chk("err", err, exp_err);
    chk("busy_after_frame", busy, 0);
    chk("pixels_outstanding", exp_q.size(), 0);
    chk("address_hold", address, last_addr);
    chk("grb_hold", {green, red, blue}, last_grb);
`ifdef WS2812_RX_PASSTHRU_EN
    chk("do_mismatch_cycles", do_bad, 0);
    chk("do_forwarded_bits", do_rises, fwd_bits);
    do_rises = 0;
`else
    if (fwd_bits < 0) $display("negative forward count %0d", fwd_bits);
`endif
  endtask

  task automatic check_all_zero();
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_led_count", led_count, 0);
    chk("rst_address", address, 0);
    chk("rst_grb", {green, red, blue}, 0);
  endtask

  initial begin
    logic [23:0] px;
    int fb;
    vecs[0] = '{npix: 2,  extra_bits: 0,  exp_count: 2, exp_err: 1'b0};
    vecs[1] = '{npix: 10, extra_bits: 0,  exp_count: 8, exp_err: 1'b0};
    vecs[2] = '{npix: 0,  extra_bits: 12, exp_count: 0, exp_err: 1'b1};
    vecs[3] = '{npix: 1,  extra_bits: 5,  exp_count: 1, exp_err: 1'b1};

    reset_n = 1'b0;
    di = 1'b0;
    repeat (5) tick();
    check_all_zero();
    reset_n = 1'b1;
    hold_low(2500);

    // Fixed pixel after the initial idle period.
    fd_count = 0;
    send_bits(24'hA53C0F, 24, 1'b1, 0);
    chk("busy_mid_frame", busy, 1);
    hold_low(TAIL);
    check_frame(1, 1, 1'b0, 0);

    for (int v = 0; v < 4; v++) begin
      run_frame(vecs[v].npix, vecs[v].extra_bits);
      fb = (vecs[v].npix > NUM_LEDS) ? 24 * (vecs[v].npix - NUM_LEDS) + vecs[v].extra_bits : 0;
      check_frame(1, vecs[v].exp_count, vecs[v].exp_err, fb);
    end

    // Runt high pulse mid-frame: error, no frame end, recovery after a long low.
    fd_count = 0;
    px = 24'($urandom);
    send_bits(px, 24, 1'b1, 0);
    di = 1'b1;
    repeat (5) tick();
    hold_low(10);
    chk("runt_err", err, 1);
    chk("runt_busy", busy, 0);
    hold_low(TAIL - 10);
    chk("runt_frame_done_pulses", fd_count, 0);
    chk("runt_err_sticky", err, 1);
    run_frame(1, 0);
    check_frame(1, 1, 1'b0, 0);

    // Line stuck high: timeout error, then a pixel sent too soon is ignored.
    fd_count = 0;
    di = 1'b1;
    repeat (80) tick();
    chk("stuck_err", err, 1);
    chk("stuck_busy", busy, 0);
    hold_low(100);
    px = 24'($urandom);
    send_bits(px, 24, 1'b0, 0);
    hold_low(TAIL);
    chk("stuck_frame_done_pulses", fd_count, 0);
    chk("stuck_err_sticky", err, 1);

    // One-cycle reset at bit 10 of pixel 0.
    fd_count = 0;
    px = 24'($urandom);
    send_bits(px, 10, 1'b0, 0);
    di = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    last_grb = '0;
    last_addr = 0;
    check_all_zero();
    hold_low(100);
    px = 24'($urandom);
    send_bits(px, 24, 1'b0, 0);
    hold_low(TAIL);
    chk("post_reset_frame_done_pulses", fd_count, 0);
    chk("post_reset_busy", busy, 0);
    run_frame(1, 0);
    check_frame(1, 1, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, meaning maximum pixels captured per frame.
REQ-002 SHALL have parameter SYSTEM_CLOCK, default 50000000, meaning clk_i frequency in Hz.
REQ-003 SHALL have one clock and synchronous active-low reset: clk_i input 1 (system clock), reset_n_i input 1 (synchronous, active-low reset).
REQ-004 SHALL have di_i input 1: asynchronous WS2812 serial data in.
REQ-005 SHALL have pix_valid_o output 1: one-cycle pulse, pixel outputs updated.
REQ-006 SHALL have address_o output $clog2(NUM_LEDS): index of the current pixel within the frame.
REQ-007 SHALL have green_o, red_o, blue_o outputs 8 each: decoded colour bytes.
REQ-008 SHALL have frame_done_o output 1: one-cycle pulse at end of frame.
REQ-009 SHALL have led_count_o output $clog2(NUM_LEDS)+1: pixels captured in the last completed frame.
REQ-010 SHALL have busy_o output 1 (frame in progress) and err_o output 1 (sticky protocol error).

Function
REQ-011 SHALL pass di_i through a 2-flop synchronizer plus one delay flop, and detect rising and falling edges on the synchronized signal only.
REQ-012 SHALL derive cycle constants as U=SYSTEM_CLOCK/1000000: T_MIN=U*15/100, T_SPLIT=U*6/10, T_MAX=U*15/10, T_RESET=U*50 (7/30/75/2500 at default).
REQ-013 SHALL implement states SYNC, IDLE, HIGH, LOW, with a pulse-width counter that saturates at T_RESET.
REQ-014 SYNC: line low for T_RESET consecutive cycles -> IDLE. Any high level restarts the count.
REQ-015 IDLE: rising edge -> HIGH. On that edge, clear the counter, bit count, pixel index and err_o, and set busy_o.
REQ-016 HIGH: on falling edge, a high width < T_MIN -> set err_o, go SYNC. Otherwise shift in bit (width >= T_SPLIT is 1, else 0), MSB first, and go LOW.
REQ-017 HIGH: high width reaching T_MAX+1 without a falling edge -> set err_o, go SYNC.
REQ-018 LOW: rising edge -> HIGH. Low width reaching T_RESET -> pulse frame_done_o, latch led_count_o, clear busy_o, go IDLE.
REQ-019 Each group of 24 bits SHALL form one pixel, in the order green[7:0], red[7:0], blue[7:0].
REQ-020 On the 24th bit, if pixel index < NUM_LEDS: update colours and address_o, pulse pix_valid_o, then increment the index (saturating at NUM_LEDS).
REQ-021 pix_valid_o SHALL assert on the 3rd rising clk_i edge after the edge that first samples the 24th bit's falling edge on di_i.
REQ-022 Colour and address outputs SHALL hold their values between pix_valid_o pulses.
REQ-023 A frame ending with a partial pixel (bit count ≠ 0) SHALL set err_o; frame_done_o still pulses, and the partial pixel is discarded.
REQ-024 err_o SHALL remain set until the next IDLE->HIGH transition.
REQ-025 Pixels beyond NUM_LEDS SHALL be decoded but not reported; led_count_o saturates at NUM_LEDS.
REQ-026 An entry to SYNC on error SHALL clear busy_o without pulsing frame_done_o.

Reset
REQ-027 With reset_n_i low at a clk_i edge: state=SYNC; all counters 0; synchronizer flops 0.
REQ-028 All outputs SHALL reset to 0, including pix_valid_o, frame_done_o, busy_o, err_o, led_count_o, address_o and the colour outputs.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no pix_valid_o or frame_done_o pulse.

Configuration
REQ-030 Macro WS2812_RX_PASSTHRU_EN SHALL, when defined, add output do_o (1 bit).
REQ-031 With the macro defined: do_o=0 until NUM_LEDS pixels are captured in the current frame. After that, do_o equals the synchronized di_i, enabled only while di_i is synchronized-low so no partial pulse is forwarded. Forwarding is disabled at frame end, error or reset.
REQ-032 Without the macro: no do_o port exists, and excess pixels are dropped (REQ-025).

Verification (SYSTEM_CLOCK=50000000; bit0 = 20 high/42 low cycles, bit1 = 40 high/22 low)
REQ-033 Reset, then 2500 low cycles, then one pixel G=0xA5 R=0x3C B=0x0F, then 2600 low -> single pix_valid_o with address_o=0 and matching bytes; frame_done_o pulse; led_count_o=1; err_o=0.
REQ-034 Ten pixels, NUM_LEDS=8 -> eight pix_valid_o pulses with addresses 0..7; led_count_o=8. With macro: do_o reproduces pixels 9-10 bit-for-bit, delayed 2 cycles.
REQ-035 High pulse of 5 cycles mid-frame -> err_o=1, busy_o=0, no frame_done_o; the next frame, after 2500 low cycles, decodes normally and clears err_o.
REQ-036 Line held high for 80 cycles -> err_o=1, state SYNC; no pix_valid_o.
REQ-037 12 bits then 2600 low -> frame_done_o pulse, err_o=1, led_count_o=0, no pix_valid_o.
REQ-038 reset_n_i low for 1 cycle at bit 10 of pixel 0 -> all outputs 0; no pulses; 2500 low cycles are required before the next frame is accepted.
